// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle between the three writeback sources and the register-file write arbiter.
// Carries the per-source valid/ready/data, the registered write port and the hazard query pair.
// The master side drives requests and queries; the slave side (arbiter) answers.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              wb_valid;
  logic [4:0]        wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              sp_valid;
  logic [DATA_W-1:0] sp_data;
  logic              sp_ready;
  logic              ln_valid;
  logic [DATA_W-1:0] ln_data;
  logic              ln_ready;
  logic              rf_write;
  logic [4:0]        rf_idx;
  logic [DATA_W-1:0] rf_data;
  logic [4:0]        qx_idx;
  logic [4:0]        qy_idx;
  logic              pend_x;
  logic              pend_y;

  modport master (
    output wb_valid, wb_idx, wb_data, input wb_ready,
    output sp_valid, sp_data, input sp_ready,
    output ln_valid, ln_data, input ln_ready,
    input  rf_write, rf_idx, rf_data,
    output qx_idx, qy_idx, input pend_x, pend_y
  );

  modport slave (
    input  wb_valid, wb_idx, wb_data, output wb_ready,
    input  sp_valid, sp_data, output sp_ready,
    input  ln_valid, ln_data, output ln_ready,
    output rf_write, rf_idx, rf_data,
    input  qx_idx, qy_idx, output pend_x, pend_y
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin share of the register-file write port between wb, s8 and ra FIFOs.
// Latency: push at edge N into an idle arbiter shows rf_write = 1 after edge N+1.
// Backpressure: *_ready = FIFO not full (registered count only); requests must be held until taken.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int S8_IDX = 30,
  parameter int RA_IDX = 31
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [4:0]    S8_I     = 5'(S8_IDX);
  localparam logic [4:0]    RA_I     = 5'(RA_IDX);

  // Source slots: 0 = general writeback, 1 = s8, 2 = ra.
  logic [CW-1:0]     cnt    [3];
  logic [PW-1:0]     wr_ptr [3];
  logic [PW-1:0]     rd_ptr [3];
  logic [DATA_W-1:0] mem    [3][DEPTH];
  // Only the general source carries a destination; s8/ra destinations are fixed.
  logic [4:0]        wb_idx_mem [DEPTH];
  logic [DEPTH-1:0]  wb_slot_vld;
  logic [1:0]        rr_ptr;

  logic              rf_write_q;
  logic [4:0]        rf_idx_q;
  logic [DATA_W-1:0] rf_data_q;

  logic [2:0]        rdy;
  logic [2:0]        nonempty;
  logic [2:0]        push;
  logic [2:0]        pop;
  logic [DATA_W-1:0] push_data [3];
  logic              grant_vld;
  logic [1:0]        grant;
  logic [4:0]        grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic              wb_hit_x;
  logic              wb_hit_y;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Slot visited k steps after the round-robin pointer, wrapping modulo 3.
  function automatic logic [1:0] rr_slot(input logic [1:0] base, input int k);
    logic [2:0] s;
    s = {1'b0, base} + 3'(k);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Ready and occupancy come from the registered counts only.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rdy[i]      = (cnt[i] < CNT_FULL);
      nonempty[i] = (cnt[i] != '0);
    end
  end

  assign bus.wb_ready = rdy[0];
  assign bus.sp_ready = rdy[1];
  assign bus.ln_ready = rdy[2];

  // Index-0 general writes complete the handshake but are dropped here.
  assign push[0] = bus.wb_valid & rdy[0] & (bus.wb_idx != 5'd0);
  assign push[1] = bus.sp_valid & rdy[1];
  assign push[2] = bus.ln_valid & rdy[2];
  assign push_data[0] = bus.wb_data;
  assign push_data[1] = bus.sp_data;
  assign push_data[2] = bus.ln_data;

  // First non-empty source at or after the round-robin pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!grant_vld && nonempty[rr_slot(rr_ptr, k)]) begin
        grant_vld = 1'b1;
        grant     = rr_slot(rr_ptr, k);
      end
    end
    pop = '0;
    if (grant_vld) pop[grant] = 1'b1;
  end

  // Head entry of the winning source, with its destination index.
  always_comb begin
    grant_data = mem[grant][rd_ptr[grant]];
    case (grant)
      2'd0:    grant_idx = wb_idx_mem[rd_ptr[0]];
      2'd1:    grant_idx = S8_I;
      default: grant_idx = RA_I;
    endcase
  end

  // Hazard match against the queued general-writeback destinations.
  always_comb begin
    wb_hit_x = 1'b0;
    wb_hit_y = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      if (wb_slot_vld[s] && wb_idx_mem[s] == bus.qx_idx) wb_hit_x = 1'b1;
      if (wb_slot_vld[s] && wb_idx_mem[s] == bus.qy_idx) wb_hit_y = 1'b1;
    end
  end

  // The output stage still counts as pending: the register file captures it a cycle later.
  assign bus.pend_x = (bus.qx_idx != 5'd0) &&
                      (wb_hit_x ||
                       (nonempty[1] && bus.qx_idx == S8_I) ||
                       (nonempty[2] && bus.qx_idx == RA_I) ||
                       (rf_write_q && rf_idx_q == bus.qx_idx));
  assign bus.pend_y = (bus.qy_idx != 5'd0) &&
                      (wb_hit_y ||
                       (nonempty[1] && bus.qy_idx == S8_I) ||
                       (nonempty[2] && bus.qy_idx == RA_I) ||
                       (rf_write_q && rf_idx_q == bus.qy_idx));

  assign bus.rf_write = rf_write_q;
  assign bus.rf_idx   = rf_idx_q;
  assign bus.rf_data  = rf_data_q;

  // FIFO bookkeeping, round-robin pointer and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      wb_slot_vld <= '0;
      rr_ptr      <= 2'd0;
      rf_write_q  <= 1'b0;
      rf_idx_q    <= 5'd0;
      rf_data_q   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= push_data[i];
          wr_ptr[i]         <= ptr_inc(wr_ptr[i]);
        end
        if (pop[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        if (push[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (pop[i] && !push[i]) cnt[i] <= cnt[i] - 1'b1;
      end
      // Push and pop never hit the same slot: that would need the FIFO empty or full.
      if (pop[0])  wb_slot_vld[rd_ptr[0]] <= 1'b0;
      if (push[0]) begin
        wb_slot_vld[wr_ptr[0]] <= 1'b1;
        wb_idx_mem[wr_ptr[0]]  <= bus.wb_idx;
      end
      rf_write_q <= grant_vld;
      if (grant_vld) begin
        rf_idx_q  <= grant_idx;
        rf_data_q <= grant_data;
        rr_ptr    <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
      end
    end
  end

endmodule
